i2c_config_sequencer: RTL and testbench
=======================================

I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 SHALL expose parameter CLK_DIV, default 1250, meaning system clocks per I2C_CLK half-period (50 MHz -> 20 kHz).
REQ-002 SHALL expose parameter DEV_ADDR, default 8'h34, meaning the 8-bit device write address placed in I2C_DATA[23:16].
REQ-003 SHALL expose parameter TIMEOUT_TICKS, default 64, meaning the maximum number of ticks allowed in any END-wait state.
REQ-004 SHALL have port CLOCK, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port START, input, 1 bit: request to run the configuration sequence.
REQ-007 SHALL have port I2C_END, input, 1 bit: END from the downstream I2C controller, asynchronous to CLOCK.
REQ-008 SHALL have port I2C_CLK, output, 1 bit: registered divided clock that drives the controller CLOCK.
REQ-009 SHALL have port I2C_DATA, output, 24 bits: {DEV_ADDR, register word}.
REQ-010 SHALL have port I2C_GO, output, 1 bit: GO to the controller.
REQ-011 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE, DONE or ERROR.
REQ-012 SHALL have port DONE, output, 1 bit: high while the state is DONE.
REQ-013 SHALL have port ERROR, output, 1 bit: high while the state is ERROR.
REQ-014 SHALL have port INDEX, output, 4 bits: current LUT entry index.

Function
REQ-015 SHALL build I2C_CLK from a 0..CLK_DIV-1 counter that toggles I2C_CLK at terminal count.
REQ-016 SHALL generate a one-cycle tick each time I2C_CLK toggles 1->0, giving one tick per I2C period.
REQ-017 SHALL pass I2C_END through a 2-flop synchronizer; all state decisions use only the synchronized copy.
REQ-018 SHALL hold a fixed 10-entry 16-bit LUT, indices 0-9: 001A, 021A, 047B, 067B, 08F8, 0A06, 0C00, 0E01, 1002, 1201.
REQ-019 SHALL drive I2C_DATA = {DEV_ADDR, LUT[INDEX]} and update it only in the LOAD state.
REQ-020 SHALL implement the states IDLE, LOAD, WAIT_LOW, WAIT_HIGH, RELEASE, NEXT, DONE and ERROR.
REQ-021 SHALL move IDLE->LOAD on START=1; DONE and ERROR also go to LOAD on START=1 with INDEX cleared to 0.
REQ-022 SHALL make LOAD last 1 cycle: latch I2C_DATA, set I2C_GO=1, then go to WAIT_LOW.
REQ-023 SHALL stay in WAIT_LOW until synchronized END=0, then go to WAIT_HIGH.
REQ-024 SHALL stay in WAIT_HIGH until synchronized END=1, then set I2C_GO=0 and go to RELEASE.
REQ-025 SHALL hold I2C_GO=0 in RELEASE for exactly 4 ticks so the controller sees GO low on at least 2 of its negedges, then go to NEXT.
REQ-026 SHALL make NEXT last 1 cycle: if INDEX==9 go to DONE, else INDEX+1 and go to LOAD.
REQ-027 SHALL count ticks in WAIT_LOW and WAIT_HIGH; reaching TIMEOUT_TICKS clears I2C_GO and enters ERROR, with INDEX frozen at the failing entry.
REQ-028 SHALL ignore START in all states other than IDLE, DONE and ERROR.
REQ-029 SHALL keep I2C_GO high continuously from LOAD until WAIT_HIGH exit or timeout, with no glitches.
REQ-030 SHALL keep the divider free-running in every state, including IDLE, DONE and ERROR.
REQ-031 SHALL make INDEX wrap impossible: it never exceeds 9.

Reset
REQ-032 SHALL, on RESET=1 at a rising CLOCK edge, force: state IDLE, INDEX 0, I2C_GO 0, I2C_DATA 0, I2C_CLK 0, divider 0, tick counter 0, synchronizer flops 1, BUSY 0, DONE 0, ERROR 0.
REQ-033 SHALL let RESET abort a sequence mid-transfer: I2C_GO is 0 on the cycle after RESET is sampled, and the sequence restarts only on a new START.

Verification
REQ-034 SHALL be verified: RESET held 3 cycles -> all outputs 0, state IDLE; I2C_CLK period 2*CLK_DIV cycles after release.
REQ-035 SHALL be verified: START pulse with a behavioural controller model -> I2C_DATA sequence 24'h34001A ... 24'h341201, 10 GO pulses, then DONE=1, BUSY=0, INDEX=9.
REQ-036 SHALL be verified: I2C_END held at 1 after GO -> ERROR=1 after TIMEOUT_TICKS ticks, I2C_GO=0, INDEX=0.
REQ-037 SHALL be verified: START pulsed during entry 3 -> no effect, sequence completes normally with 10 transfers.
REQ-038 SHALL be verified: RESET during WAIT_HIGH of entry 5 -> I2C_GO=0 next cycle, INDEX=0; a new START reruns from 24'h34001A.
REQ-039 SHALL be verified: after the full sequence completes, each GO low interval >= 4 I2C_CLK periods, and every GO rise is preceded by stable I2C_DATA.

Source files
------------

// File: rtl/i2c_config_sequencer.sv
// I2C register configuration sequencer.
// Walks a fixed 10-entry register table through a GO/END I2C controller.
module i2c_config_sequencer #(
    parameter int         CLK_DIV       = 1250,
    parameter logic [7:0] DEV_ADDR      = 8'h34,
    parameter int         TIMEOUT_TICKS = 64
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic        I2C_END,
    output logic        I2C_CLK,
    output logic [23:0] I2C_DATA,
    output logic        I2C_GO,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [3:0]  INDEX
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TB = $clog2(TIMEOUT_TICKS + 1);
    localparam int TW = (TB > 3) ? TB : 3;
    localparam logic [DW-1:0] DIV_TC  = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] REL_LAST = TW'(3);
    localparam logic [3:0]    LAST_IDX = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RELEASE,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_div;
    logic          r_i2c_clk;
    logic          r_tick;
    logic          r_end_s1, r_end_s2;
    logic [3:0]    r_index, w_index_nxt;
    logic          r_go, w_go_nxt;
    logic [23:0]   r_data, w_data_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic          w_div_tc;

    function automatic logic [15:0] lut(input logic [3:0] idx);
        case (idx)
            4'd0:    lut = 16'h001A;
            4'd1:    lut = 16'h021A;
            4'd2:    lut = 16'h047B;
            4'd3:    lut = 16'h067B;
            4'd4:    lut = 16'h08F8;
            4'd5:    lut = 16'h0A06;
            4'd6:    lut = 16'h0C00;
            4'd7:    lut = 16'h0E01;
            4'd8:    lut = 16'h1002;
            4'd9:    lut = 16'h1201;
            default: lut = 16'h0000;
        endcase
    endfunction

    assign w_div_tc = (r_div == DIV_TC);

    // Free-running divider; tick marks the cycle in which I2C_CLK falls
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_div     <= '0;
            r_i2c_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_div_tc & r_i2c_clk;
            if (w_div_tc) begin
                r_div     <= '0;
                r_i2c_clk <= ~r_i2c_clk;
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    // Two-flop synchronizer for the controller END (idle level is high)
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_end_s1 <= 1'b1;
            r_end_s2 <= 1'b1;
        end else begin
            r_end_s1 <= I2C_END;
            r_end_s2 <= r_end_s1;
        end
    end

    // Sequencer state and datapath registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_go    <= 1'b0;
            r_data  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_go    <= w_go_nxt;
            r_data  <= w_data_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Next-state logic; the data word is loaded as LOAD is entered so it
    // is already stable for the whole LOAD cycle before GO rises
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_go_nxt    = r_go;
        w_data_nxt  = r_data;
        w_tcnt_nxt  = r_tcnt;
        unique case (r_state)
            S_IDLE: begin
                if (START) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_go_nxt    = 1'b1;
                w_tcnt_nxt  = '0;
                w_state_nxt = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!r_end_s2) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_WAIT_HIGH;
                end else if (r_tick) begin
                    if (r_tcnt == TO_LAST) begin
                        w_go_nxt    = 1'b0;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TW'(1);
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (r_end_s2) begin
                    w_go_nxt    = 1'b0;
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_RELEASE;
                end else if (r_tick) begin
                    if (r_tcnt == TO_LAST) begin
                        w_go_nxt    = 1'b0;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TW'(1);
                    end
                end
            end
            S_RELEASE: begin
                if (r_tick) begin
                    if (r_tcnt == REL_LAST) w_state_nxt = S_NEXT;
                    else w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            S_NEXT: begin
                if (r_index == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_index_nxt = r_index + 4'd1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE, S_ERROR: begin
                if (START) begin
                    w_index_nxt = '0;
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_LOAD && r_state != S_LOAD)
            w_data_nxt = {DEV_ADDR, lut(w_index_nxt)};
    end

    assign I2C_CLK  = r_i2c_clk;
    assign I2C_DATA = r_data;
    assign I2C_GO   = r_go;
    assign INDEX    = r_index;
    assign DONE     = (r_state == S_DONE);
    assign ERROR    = (r_state == S_ERROR);
    assign BUSY     = !(r_state == S_IDLE || r_state == S_DONE ||
                        r_state == S_ERROR);

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer.
// Random-latency controller model and a table of expected register words.
module tb_i2c_config_sequencer;

    localparam int         CLK_DIV = 4;
    localparam int         TO      = 16;
    localparam logic [7:0] DEV     = 8'h34;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        I2C_END = 1'b1;
    logic        I2C_CLK;
    logic [23:0] I2C_DATA;
    logic        I2C_GO;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic [3:0]  INDEX;

    i2c_config_sequencer #(
        .CLK_DIV      (CLK_DIV),
        .DEV_ADDR     (DEV),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .START   (START),
        .I2C_END (I2C_END),
        .I2C_CLK (I2C_CLK),
        .I2C_DATA(I2C_DATA),
        .I2C_GO  (I2C_GO),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERROR   (ERROR),
        .INDEX   (INDEX)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_word [10] = '{16'h001A, 16'h021A, 16'h047B, 16'h067B,
                                   16'h08F8, 16'h0A06, 16'h0C00, 16'h0E01,
                                   16'h1002, 16'h1201};

    // monitor records, one entry per GO rise
    logic [23:0] rise_data [$];
    bit          rise_stable [$];
    int          rise_low [$];
    int          hi_falls;
    int          last_hi_falls;
    int          low_falls;

    // controller model controls
    bit ctrl_en  = 1'b0;
    int stall_at = -1;
    int ctrl_xf  = 0;

    // GO/data/clock monitor
    initial begin : mon
        logic        p_clk;
        logic        p_go;
        logic [23:0] p_data;
        bit          fall;
        p_clk = 0; p_go = 0; p_data = 0;
        hi_falls = 0; last_hi_falls = 0; low_falls = 0;
        forever begin
            @(negedge CLOCK);
            fall = p_clk && !I2C_CLK;
            if (I2C_GO && !p_go) begin
                rise_data.push_back(I2C_DATA);
                rise_stable.push_back(I2C_DATA === p_data);
                rise_low.push_back(low_falls);
                hi_falls = 0;
            end
            if (!I2C_GO && p_go) begin
                last_hi_falls = hi_falls;
                low_falls = 0;
            end
            if (fall) begin
                if (I2C_GO) hi_falls++;
                else low_falls++;
            end
            p_clk = I2C_CLK; p_go = I2C_GO; p_data = I2C_DATA;
        end
    end

    // Behavioural I2C controller: END drops, then rises, after random delays
    initial begin : ctrl
        int cst;
        int cnt;
        cst = 0; cnt = 0;
        forever begin
            @(negedge CLOCK);
            if (RESET || !ctrl_en) begin
                cst = 0; I2C_END = 1'b1;
            end else begin
                case (cst)
                    0: if (I2C_GO) begin
                        cnt = $urandom_range(5, 30); cst = 1;
                    end
                    1: if (!I2C_GO) begin
                        cst = 0; I2C_END = 1'b1;
                    end else if (cnt == 0) begin
                        I2C_END = 1'b0; cnt = $urandom_range(10, 40); cst = 2;
                    end else cnt--;
                    2: if (!I2C_GO) begin
                        cst = 0; I2C_END = 1'b1; ctrl_xf++;
                    end else if (cnt == 0) begin
                        if (ctrl_xf != stall_at) begin
                            I2C_END = 1'b1; cst = 3; ctrl_xf++;
                        end
                    end else cnt--;
                    default: if (!I2C_GO) cst = 0;
                endcase
            end
        end
    end

    task automatic pulse_start();
        @(negedge CLOCK); START = 1'b1;
        @(negedge CLOCK); START = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (DONE !== 1'b1 && ERROR !== 1'b1 && n < lim) begin
            @(negedge CLOCK); n++;
        end
    endtask

    task automatic test_reset();
        int n, h, l;
        @(negedge CLOCK); RESET = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        n_checks++;
        if ({I2C_CLK, I2C_GO, BUSY, DONE, ERROR, INDEX, I2C_DATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clk=%b go=%b busy=%b done=%b err=%b idx=%0d data=%h, want all 0",
                     I2C_CLK, I2C_GO, BUSY, DONE, ERROR, INDEX, I2C_DATA);
        end
        RESET = 1'b0;
        n = 0;
        while (I2C_CLK !== 1'b1 && n < 100) begin @(negedge CLOCK); n++; end
        n_checks++;
        if (n !== CLK_DIV) begin
            n_fail++; $display("FAIL first_rise: got %0d cycles, want %0d", n, CLK_DIV);
        end
        h = 0;
        while (I2C_CLK === 1'b1 && h < 100) begin @(negedge CLOCK); h++; end
        l = 0;
        while (I2C_CLK !== 1'b1 && l < 100) begin @(negedge CLOCK); l++; end
        n_checks++;
        if (h !== CLK_DIV) begin
            n_fail++; $display("FAIL clk_high: got %0d, want %0d", h, CLK_DIV);
        end
        n_checks++;
        if (h + l !== 2 * CLK_DIV) begin
            n_fail++; $display("FAIL clk_period: got %0d, want %0d", h + l, 2 * CLK_DIV);
        end
        n_checks++;
        if ({BUSY, I2C_GO} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b go=%b, want 0 0", BUSY, I2C_GO);
        end
    endtask

    task automatic test_sequence();
        int base = rise_data.size();
        ctrl_en = 1'b1;
        pulse_start();
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++; $display("FAIL seq_busy: got %b, want 1", BUSY);
        end
        wait_done(5000);
        repeat (2) @(negedge CLOCK);
        n_checks++;
        if ({DONE, BUSY, ERROR, I2C_GO, INDEX} !== {4'b1000, 4'd9}) begin
            n_fail++;
            $display("FAIL seq_end: done=%b busy=%b err=%b go=%b idx=%0d, want 1 0 0 0 9",
                     DONE, BUSY, ERROR, I2C_GO, INDEX);
        end
        n_checks++;
        if (rise_data.size() - base !== 10) begin
            n_fail++; $display("FAIL seq_count: got %0d GO pulses, want 10", rise_data.size() - base);
        end
        for (int i = 0; i < 10 && base + i < rise_data.size(); i++) begin
            n_checks++;
            if (rise_data[base+i] !== {DEV, exp_word[i]}) begin
                n_fail++; $display("FAIL seq_data[%0d]: got %h, want %h", i, rise_data[base+i], {DEV, exp_word[i]});
            end
            n_checks++;
            if (rise_stable[base+i] !== 1'b1) begin
                n_fail++; $display("FAIL seq_stable[%0d]: data changed on GO rise, want stable", i);
            end
            if (i > 0) begin
                n_checks++;
                if (rise_low[base+i] < 4) begin
                    n_fail++; $display("FAIL seq_gap[%0d]: got %0d clk periods low, want >= 4", i, rise_low[base+i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int base = rise_data.size();
        ctrl_en = 1'b0;
        pulse_start();
        wait_done(5000);
        @(negedge CLOCK);
        n_checks++;
        if ({ERROR, DONE, BUSY, I2C_GO, INDEX} !== {4'b1000, 4'd0}) begin
            n_fail++;
            $display("FAIL to_state: err=%b done=%b busy=%b go=%b idx=%0d, want 1 0 0 0 0",
                     ERROR, DONE, BUSY, I2C_GO, INDEX);
        end
        n_checks++;
        if (last_hi_falls !== TO) begin
            n_fail++; $display("FAIL to_ticks: got %0d ticks with GO high, want %0d", last_hi_falls, TO);
        end
        n_checks++;
        if (rise_data.size() - base !== 1) begin
            n_fail++; $display("FAIL to_count: got %0d GO pulses, want 1", rise_data.size() - base);
        end else begin
            n_checks++;
            if (rise_data[base] !== {DEV, exp_word[0]}) begin
                n_fail++; $display("FAIL to_data: got %h, want %h", rise_data[base], {DEV, exp_word[0]});
            end
        end
    endtask

    task automatic test_stall_timeout();
        int k = $urandom_range(1, 8);
        int base = rise_data.size();
        stall_at = ctrl_xf + k;
        ctrl_en = 1'b1;
        pulse_start();
        wait_done(5000);
        @(negedge CLOCK);
        n_checks++;
        if ({ERROR, I2C_GO, INDEX} !== {1'b1, 1'b0, 4'(k)}) begin
            n_fail++; $display("FAIL stall: err=%b go=%b idx=%0d, want 1 0 %0d", ERROR, I2C_GO, INDEX, k);
        end
        n_checks++;
        if (rise_data.size() - base !== k + 1) begin
            n_fail++; $display("FAIL stall_count: got %0d, want %0d", rise_data.size() - base, k + 1);
        end
        stall_at = -1;
    endtask

    task automatic test_start_ignored();
        int base = rise_data.size();
        int n = 0;
        pulse_start();
        while (rise_data.size() - base < 4 && n < 3000) begin @(negedge CLOCK); n++; end
        repeat (3) begin
            START = 1'b1; @(negedge CLOCK);
        end
        START = 1'b0;
        n_checks++;
        if ({BUSY, INDEX} !== {1'b1, 4'd3}) begin
            n_fail++; $display("FAIL ign_mid: busy=%b idx=%0d, want 1 3", BUSY, INDEX);
        end
        wait_done(5000);
        @(negedge CLOCK);
        n_checks++;
        if ({DONE, INDEX} !== {1'b1, 4'd9}) begin
            n_fail++; $display("FAIL ign_end: done=%b idx=%0d, want 1 9", DONE, INDEX);
        end
        n_checks++;
        if (rise_data.size() - base !== 10) begin
            n_fail++; $display("FAIL ign_count: got %0d, want 10", rise_data.size() - base);
        end
        for (int i = 0; i < 10 && base + i < rise_data.size(); i++) begin
            n_checks++;
            if (rise_data[base+i] !== {DEV, exp_word[i]}) begin
                n_fail++; $display("FAIL ign_data[%0d]: got %h, want %h", i, rise_data[base+i], {DEV, exp_word[i]});
            end
        end
    endtask

    task automatic test_reset_abort();
        int base = rise_data.size();
        int n = 0;
        int after;
        pulse_start();
        while (!(rise_data.size() - base == 6 && I2C_END === 1'b0) && n < 3000) begin
            @(negedge CLOCK); n++;
        end
        repeat (4) @(negedge CLOCK);
        n_checks++;
        if ({I2C_GO, INDEX} !== {1'b1, 4'd5}) begin
            n_fail++; $display("FAIL abort_pre: go=%b idx=%0d, want 1 5", I2C_GO, INDEX);
        end
        RESET = 1'b1;
        @(negedge CLOCK);
        n_checks++;
        if ({I2C_GO, BUSY, INDEX} !== {2'b00, 4'd0}) begin
            n_fail++; $display("FAIL abort_rst: go=%b busy=%b idx=%0d, want 0 0 0", I2C_GO, BUSY, INDEX);
        end
        RESET = 1'b0;
        after = rise_data.size();
        repeat (60) @(negedge CLOCK);
        n_checks++;
        if ({BUSY, I2C_GO} !== 2'b00 || rise_data.size() !== after) begin
            n_fail++; $display("FAIL abort_idle: busy=%b go=%b, want idle with no restart", BUSY, I2C_GO);
        end
        pulse_start();
        wait_done(5000);
        @(negedge CLOCK);
        n_checks++;
        if (rise_data.size() - after !== 10 || DONE !== 1'b1) begin
            n_fail++; $display("FAIL rerun_count: got %0d pulses done=%b, want 10 1", rise_data.size() - after, DONE);
        end
        for (int i = 0; i < 10 && after + i < rise_data.size(); i++) begin
            n_checks++;
            if (rise_data[after+i] !== {DEV, exp_word[i]}) begin
                n_fail++; $display("FAIL rerun_data[%0d]: got %h, want %h", i, rise_data[after+i], {DEV, exp_word[i]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_timeout();
        test_stall_timeout();
        test_start_ignored();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
